// File: rtl/dds_nco.sv
// Phase-continuous NCO: signed FTW accumulates into a phase register, which is
// folded onto a quarter-wave sine ROM and sign-restored over a 4-register pipeline.
module dds_nco #(
  parameter int FTW_W      = 12,
  parameter int ACC_W      = 16,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_W      = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sync_clear,
  input  logic signed [FTW_W-1:0] control,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid
);

  localparam int LUT_N = 2 ** LUT_ADDR_W;
  localparam int MAG_W = OUT_W - 1;
  localparam int LSB_W = ACC_W - 2 - LUT_ADDR_W;

  // Half-LSB phase offset keeps entries symmetric, so ~idx folding needs no edge fix-up.
  function automatic logic [MAG_W-1:0] rom_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** MAG_W) - 1);
    ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_N);
    return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [MAG_W-1:0] rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = rom_entry(k);
    assign rom[k] = ENTRY;
  end

  logic [ACC_W-1:0] ftw_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p1;
  logic             v1;

  assign ftw_ext = {{(ACC_W - FTW_W){control[FTW_W-1]}}, control};

  // p1 carries the pre-add phase, so the first enabled step after a restart is phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      p1  <= '0;
      v1  <= 1'b0;
    end else if (sync_clear) begin
      if (en) begin
        acc <= ftw_ext;
        p1  <= '0;
        v1  <= 1'b1;
      end else begin
        acc <= '0;
        v1  <= 1'b0;
      end
    end else if (en) begin
      acc <= acc + ftw_ext;
      p1  <= acc;
      v1  <= 1'b1;
    end else begin
      v1 <= 1'b0;
    end
  end

  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [LUT_ADDR_W-1:0] addr_fold;
  logic [LSB_W-1:0]      unused_phase_lsbs;

  assign quad              = p1[ACC_W-1 -: 2];
  assign idx               = p1[ACC_W-3 -: LUT_ADDR_W];
  assign unused_phase_lsbs = p1[LSB_W-1:0];
  assign addr_fold         = quad[0] ? ~idx : idx;

  logic [LUT_ADDR_W-1:0] addr2;
  logic                  neg2;
  logic                  v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr2 <= '0;
      neg2  <= 1'b0;
      v2    <= 1'b0;
    end else begin
      addr2 <= addr_fold;
      neg2  <= quad[1];
      v2    <= v1;
    end
  end

  logic [MAG_W-1:0] mag3;
  logic             neg3;
  logic             v3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag3 <= '0;
      neg3 <= 1'b0;
      v3   <= 1'b0;
    end else begin
      mag3 <= rom[addr2];
      neg3 <= neg2;
      v3   <= v2;
    end
  end

  logic signed [OUT_W-1:0] mag_s;

  assign mag_s = {1'b0, mag3};

  // Magnitude never reaches 2^(OUT_W-1), so negation cannot overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      if (v3) sample <= neg3 ? -mag_s : mag_s;
      sample_valid <= v3;
    end
  end

endmodule

// File: tb/tb_dds_nco.sv
// Directed bench for dds_nco: known ROM points, latency, bubbles, hops, restart, reset.
module tb_dds_nco;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic               sync_clear = 1'b0;
  logic signed [11:0] control = '0;
  logic signed [11:0] sample;
  logic               sample_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int hold_err = 0;
  int prev_sample = 0;
  int got[$];
  int vcyc[$];
  int ecyc[$];

  dds_nco dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sync_clear   (sync_clear),
    .control      (control),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      if (sample_valid) begin
        got.push_back(int'(sample));
        vcyc.push_back(cyc);
      end else if (int'(sample) != prev_sample) begin
        hold_err++;
      end
    end
    prev_sample = int'(sample);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    sync_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    got.delete();
    vcyc.delete();
    ecyc.delete();
    hold_err = 0;
  endtask

  initial begin
    int c0;
    int mono_err;
    int lat_err;
    int n;

    tick();
    tick();
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    reset = 1'b0;
    got.delete();
    vcyc.delete();
    for (int i = 0; i < 10; i++) tick();
    check("idle_strobes", got.size(), 0);
    check("idle_sample", int'(sample), 0);
    check("idle_acc", int'(dut.acc), 0);

    // constant phase 0
    c0 = cyc;
    control = 12'sd0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("dc_count", got.size(), 10);
    check("dc_first_cyc", vcyc[0], c0 + 4);
    check("dc_first", got[0], 6);
    check("dc_last", got[9], 6);

    // 64-sample period, forward
    do_reset();
    control = 12'sd1024;
    en = 1'b1;
    for (int i = 0; i < 65; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("fwd_count", got.size(), 65);
    check("fwd_i0", got[0], 6);
    check("fwd_i8", got[8], 1452);
    check("fwd_i16", got[16], 2047);
    check("fwd_i24", got[24], 1443);
    check("fwd_i32", got[32], -6);
    check("fwd_i48", got[48], -2047);
    check("fwd_i64", got[64], 6);
    mono_err = 0;
    for (int i = 1; i <= 16; i++) if (got[i] <= got[i-1]) mono_err++;
    check("fwd_monotonic_err", mono_err, 0);

    // reverse rotation
    do_reset();
    control = -12'sd1024;
    en = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rev_i0", got[0], 6);
    check("rev_i16", got[16], -2047);
    check("rev_i48", got[48], 2047);

    // en every third cycle
    do_reset();
    control = 12'sd1024;
    for (int i = 0; i < 20; i++) begin
      en = 1'b1;
      tick();
      ecyc.push_back(cyc);
      en = 1'b0;
      tick();
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("gap_count", got.size(), 20);
    lat_err = 0;
    n = (got.size() < 20) ? got.size() : 20;
    for (int i = 0; i < n; i++) if (vcyc[i] - ecyc[i] != 3) lat_err++;
    check("gap_latency_err", lat_err, 0);
    check("gap_i8", got[8], 1452);
    check("gap_i16", got[16], 2047);
    check("gap_hold_err", hold_err, 0);

    // hop, then restart
    do_reset();
    control = 12'sd1024;
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("hop_acc_switch", int'(dut.acc), 10240);
    control = 12'sd12;
    for (int i = 0; i < 5; i++) tick();
    check("hop_acc_cont", int'(dut.acc), 10300);
    for (int i = 0; i < 5; i++) tick();
    sync_clear = 1'b1;
    tick();
    sync_clear = 1'b0;
    check("sync_acc", int'(dut.acc), 12);
    tick();
    tick();
    tick();
    check("sync_valid", int'(sample_valid), 1);
    check("sync_sample", int'(sample), 6);

    // reset mid-stream
    do_reset();
    control = 12'sd1024;
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_valid", int'(sample_valid), 1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(sample_valid), 0);
    check("mid_rst_sample", int'(sample), 0);
    tick();
    en = 1'b0;
    reset = 1'b0;
    got.delete();
    for (int i = 0; i < 8; i++) tick();
    check("post_rst_strobes", got.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_nco.md
Name: dds_nco

Overview:
- Phase-continuous direct digital synthesizer. It sits directly downstream of the frequency-hopping controller and consumes its signed 12-bit `control` word as the frequency tuning word (FTW).
- Each enabled cycle it advances a phase accumulator by the FTW and maps the phase through a quarter-wave sine ROM.
- Output is a signed sine sample stream with a valid strobe, feeding the DAC/output stage.

Parameters:
- FTW_W, 12, width of signed tuning word input
- ACC_W, 16, phase accumulator width (modulo 2^ACC_W)
- LUT_ADDR_W, 8, quarter-wave ROM address width (2^LUT_ADDR_W entries)
- OUT_W, 12, signed output sample width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  sample strobe; one phase step per cycle with en=1
- sync_clear  input  1  synchronous phase restart
- control  input  FTW_W (signed)  tuning word; phase increment per enabled cycle
- sample  output  OUT_W (signed)  sine sample
- sample_valid  output  1  one-cycle strobe, sample updated this cycle

Behaviour:
- Reset (async, high): accumulator=0, all pipeline registers=0, sample=0, sample_valid=0.
- Stage 0, accumulator, on en=1:
  - acc <= acc + sext(control) to ACC_W, two's-complement wrap; negative FTW runs backwards.
  - p1 <= acc (pre-add value); v1 <= 1.
  - en=0: acc and p1 hold; v1 <= 0.
- sync_clear=1 has priority over en:
  - with en=1: p1 <= 0, acc <= sext(control), v1 <= 1 (output restarts at phase 0).
  - with en=0: acc <= 0, v1 <= 0.
- Stage 1, fold:
  - quadrant q = p1[ACC_W-1:ACC_W-2].
  - idx = p1[ACC_W-3:ACC_W-2-LUT_ADDR_W]; lower bits truncated.
  - q=0: addr=idx, pos; q=1: addr=~idx, pos; q=2: addr=idx, neg; q=3: addr=~idx, neg.
  - Register addr, sign flag, v2.
- Stage 2, ROM:
  - Registered read. Entry k = round((2^(OUT_W-1)-1)*sin(pi/2*(k+0.5)/2^LUT_ADDR_W)).
  - The half-LSB offset makes folding exact with no special case at quadrant edges.
  - Register mag, sign, v3.
- Stage 3, sign:
  - sample <= sign ? -mag : mag, updated only when v3=1; otherwise holds.
  - sample_valid <= v3.
  - mag ≤ 2^(OUT_W-1)-1, so negation cannot overflow.
- Latency: en (or sync_clear+en) in cycle N gives sample_valid=1 and the matching sample in cycle N+3. Throughput is one sample per cycle with en held high.
- Control changes take effect on the next enabled step. There is no phase discontinuity: acc is never reloaded except by sync_clear/reset.
- en gaps insert bubbles; pipeline validity follows en exactly, with no sample dropped or duplicated.
- Reset mid-stream clears all in-flight valids; no sample_valid appears for pre-reset en cycles.
- Output frequency = f_clk_en * control / 2^ACC_W. Defaults: control 94 gives ~697.2 samples/period; control 12 gives ~5461.3.
- ROM is generated at elaboration (function or initial block); no external file.

Test Plan:
- Reset asserted, then released with en=0 -> sample=0, sample_valid=0 indefinitely; acc=0.
- control=0, en=1 continuously from cycle 0 -> sample_valid rises at cycle 3; sample=6 constant thereafter.
- control=1024, en=1 continuously -> 64-sample period:
  - samples index 0,16,32,48,64 = 6, 2047, -6, -2047, 6.
  - sequence is monotonic rising over indices 0..16.
- control=-1024 -> sample index 16 = -2047, index 48 = 2047 (reverse rotation).
- en pulsed every 3rd cycle, control=1024 -> sample_valid exactly 3 cycles after each en; same value sequence as the continuous case; sample holds between strobes.
- Hop and restart cases:
  - control 1024 for 10 steps, then 12 -> acc=10240 at the switch; subsequent phases 10240+12k (phase-continuous).
  - sync_clear+en at step 20 -> the sample 3 cycles later = 6.
  - reset asserted mid-stream -> sample_valid=0 next cycle and no stale strobes after release.
